alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WIDTH, 16, operand/result width.
REQ-002 Parameter IMM_WIDTH, 5, immediate field width.
REQ-003 Parameter OP_LAST, 4'h8, highest legal opcode; larger codes are illegal.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 reset  in  1  reset, synchronous and active-high.
REQ-006 req_valid/req_ready  in/out  1/1  request handshake.
REQ-007 req_op/req_a/req_b/req_imm  in  4/WIDTH/WIDTH/IMM_WIDTH  requested operation and operands.
REQ-008 alu_op/alu_a/alu_b/alu_imm  out  4/WIDTH/WIDTH/IMM_WIDTH  ALU drive, all registered.
REQ-009 alu_out  in  WIDTH  ALU result, registered in the ALU with 1-cycle latency; alu_zero, alu_sign are ignored.
REQ-010 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-011 rsp_data/rsp_zero/rsp_sign/rsp_err  out  WIDTH/1/1/1  result, flags, error.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 States: IDLE, ISSUE, WAIT, CAPTURE, RESP; one request in flight.
REQ-014 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid && req_ready.
REQ-015 On accept with a legal op, SHALL register req_* into alu_* and go to ISSUE.
REQ-016 ISSUE: ALU samples alu_* at this edge; next state WAIT.
REQ-017 WAIT: alu_op SHALL return to 4'hF (NOP; ALU holds its output, RNG state untouched); next state CAPTURE.
REQ-018 CAPTURE: SHALL latch rsp_data = alu_out, rsp_zero = (alu_out == 0), rsp_sign = alu_out[WIDTH-1], rsp_err = 0; next state RESP.
REQ-019 Accept-to-rsp_valid latency SHALL be 4 cycles for legal ops.
REQ-020 Illegal op (> OP_LAST), or op 4'h5 or 4'h7 with req_b == 0, SHALL NOT be issued: go directly to RESP with rsp_err = 1, rsp_data = 0, rsp_zero = 1, rsp_sign = 0 (latency 1 cycle).
REQ-021 Op 4'h8 (random) with req_a == 0 is legal and SHALL be issued normally.
REQ-022 RESP: rsp_valid = 1, rsp_* stable until a cycle with rsp_ready = 1; then go to IDLE.
REQ-023 A new request SHALL NOT be accepted in the same cycle a response completes; the earliest accept is the following cycle.
REQ-024 alu_op SHALL be 4'hF in every state except ISSUE; alu_a/alu_b/alu_imm hold their last values.
REQ-025 req_* changes outside an accept cycle SHALL have no effect.

Reset
REQ-026 While reset = 1 at a posedge: state = IDLE, req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_zero = 0, rsp_sign = 0, rsp_err = 0, busy = 0, alu_op = 4'hF, alu_a = alu_b = 0, alu_imm = 0.
REQ-027 req_ready SHALL rise the cycle after reset deasserts.
REQ-028 Reset in any state SHALL abort the transaction with no response; an ALU result arriving after the abort is discarded.

Structure
REQ-029 Shared package alu_pkg SHALL hold opcode constants (OP_ADD 0 ... OP_RAND 8, OP_NOP 4'hF) and the state encoding; the ALU and this block use the same constants.
REQ-030 One sub-module, alu_op_check, SHALL be combinational: (op, b) -> legal/err.

Verification
REQ-031 ADD: op 0, a 16'h0003, b 16'h0004, imm 5'h1F -> rsp_data 16'h0006, zero 0, sign 0, err 0, rsp_valid 4 cycles after accept.
REQ-032 SUB: op 1, a 5, b 5, imm 0 -> rsp_data 0, zero 1; op 1, a 0, b 1 -> 16'hFFFF, sign 1.
REQ-033 Divide by zero: op 7, b 0 -> rsp_err 1 one cycle after accept, alu_op stays 4'hF throughout.
REQ-034 Illegal op 4'hA -> rsp_err 1, no ALU issue; next legal request completes normally.
REQ-035 Backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_* stable, req_ready 0, busy 1; one cycle after rsp_ready, req_ready = 1.
REQ-036 Reset asserted in WAIT -> no rsp_valid, all outputs at reset values next cycle; a following op 3 (a 16'h00F0, b 16'h000F, imm 0) -> 16'h00FF.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and sequencer state encoding shared by the ALU and its sequencer.
package alu_pkg;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_DIV  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_MOD  = 4'h7;
    localparam logic [3:0] OP_RAND = 4'h8;
    localparam logic [3:0] OP_NOP  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_RESP
    } state_t;
endpackage

// File: rtl/alu_op_check.sv
// alu_op_check: flags opcodes beyond OP_LAST and divide/modulo by zero as not issuable.
module alu_op_check
    import alu_pkg::*;
#(
    parameter int         WIDTH   = 16,
    parameter logic [3:0] OP_LAST = OP_RAND
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] b,
    output logic             legal,
    output logic             err
);
    assign legal = (op <= OP_LAST) && !(((op == OP_DIV) || (op == OP_MOD)) && (b == '0));
    assign err   = !legal;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one request at a time, drives a 1-cycle-latency ALU and returns the result with flags.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int         WIDTH     = 16,
    parameter int         IMM_WIDTH = 5,
    parameter logic [3:0] OP_LAST   = 4'h8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_op,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    input  logic [IMM_WIDTH-1:0] req_imm,
    output logic [3:0]           alu_op,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [IMM_WIDTH-1:0] alu_imm,
    input  logic [WIDTH-1:0]     alu_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_zero,
    output logic                 rsp_sign,
    output logic                 rsp_err,
    output logic                 busy
);
    state_t state;
    logic   legal, err;

    alu_op_check #(.WIDTH(WIDTH), .OP_LAST(OP_LAST)) u_check (
        .op   (req_op),
        .b    (req_b),
        .legal(legal),
        .err  (err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_sign  <= 1'b0;
            rsp_err   <= 1'b0;
            alu_op    <= OP_NOP;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_imm   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // req_ready stays low for one cycle after reset, then rises
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (legal) begin
                            alu_op  <= req_op;
                            alu_a   <= req_a;
                            alu_b   <= req_b;
                            alu_imm <= req_imm;
                            state   <= S_ISSUE;
                        end else begin
                            rsp_data  <= '0;
                            rsp_zero  <= 1'b1;
                            rsp_sign  <= 1'b0;
                            rsp_err   <= err;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    alu_op <= OP_NOP;
                    state  <= S_WAIT;
                end
                S_WAIT: state <= S_CAPTURE;
                S_CAPTURE: begin
                    rsp_data  <= alu_out;
                    rsp_zero  <= (alu_out == '0);
                    rsp_sign  <= alu_out[WIDTH-1];
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer against a behavioural ALU and checks responses, latency and handshakes.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'h0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [4:0]  req_imm = '0;
    logic [3:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    logic [4:0]  alu_imm;
    logic [15:0] alu_out = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_zero, rsp_sign, rsp_err, busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] lfsr = 16'hACE1;
    logic [15:0] mrng = 16'hACE1;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_imm(req_imm),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm),
        .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .rsp_err(rsp_err),
        .busy(busy)
    );

    function automatic logic [15:0] calc(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [4:0] imm);
        logic [15:0] s;
        s = {{11{imm[4]}}, imm};
        case (op)
            4'h0: return a + b + s;
            4'h1: return a - b + s;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return (b == 0) ? 16'h0 : a / b;
            4'h6: return a << imm[3:0];
            4'h7: return (b == 0) ? 16'h0 : a % b;
            default: return 16'h0;
        endcase
    endfunction

    function automatic logic [15:0] step(input logic [15:0] r);
        return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    endfunction

    // Behavioural ALU: samples when alu_op is not NOP, result visible one cycle later
    always @(posedge clk) begin
        if (alu_op != 4'hF) begin
            alu_out <= (alu_op == 4'h8) ? lfsr : calc(alu_op, alu_a, alu_b, alu_imm);
            if (alu_op == 4'h8) lfsr <= step(lfsr);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input string nm, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [4:0] imm, input logic [15:0] ed, input logic ez, input logic es,
                           input logic ee, input int hold);
        int n;
        logic [15:0] d0;
        req_op = op; req_a = a; req_b = b; req_imm = imm; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk({nm, " accept timeout"}, req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 4'($urandom); req_a = 16'($urandom); req_b = 16'($urandom); req_imm = 5'($urandom);
        n = 1;
        while (!rsp_valid && n < 10) begin
            chk({nm, " alu_op"}, alu_op, (n == 1 && !ee) ? op : 4'hF);
            if (n == 1) begin
                chk({nm, " alu_a"}, alu_a, a);
                chk({nm, " alu_b"}, alu_b, b);
                chk({nm, " alu_imm"}, alu_imm, imm);
            end
            chk({nm, " busy"}, busy, 1);
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, ee ? 1 : 4);
        chk({nm, " resp alu_op"}, alu_op, 4'hF);
        chk({nm, " data"}, rsp_data, ed);
        chk({nm, " flags"}, {rsp_zero, rsp_sign, rsp_err}, {ez, es, ee});
        d0 = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, " hold valid"}, rsp_valid, 1);
            chk({nm, " hold data"}, rsp_data, d0);
            chk({nm, " hold ready/busy"}, {req_ready, busy}, 2'b01);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, " after rsp"}, {req_ready, rsp_valid, busy}, 3'b100);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, b;
        logic [4:0]  imm;
        logic [15:0] d;
        logic        z, s, e;
    } vec_t;
    vec_t tbl[10];

    initial begin
        logic [3:0] op;
        logic [15:0] a, b, ed;
        logic [4:0] imm;
        logic legal;
        tbl[0] = '{4'h0, 16'h0003, 16'h0004, 5'h1F, 16'h0006, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{4'h1, 16'h0005, 16'h0005, 5'h00, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{4'h1, 16'h0000, 16'h0001, 5'h00, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{4'h7, 16'h1234, 16'h0000, 5'h00, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{4'hA, 16'h0001, 16'h0002, 5'h03, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{4'h3, 16'h00F0, 16'h000F, 5'h00, 16'h00FF, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{4'h5, 16'h0100, 16'h0007, 5'h00, 16'h0024, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{4'h6, 16'h8001, 16'h1111, 5'h01, 16'h0002, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{4'h4, 16'hFFFF, 16'h7FFF, 5'h00, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{4'hF, 16'h0001, 16'h0005, 5'h00, 16'h0000, 1'b1, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        chk("reset outputs", {req_ready, rsp_valid, busy, rsp_zero, rsp_sign, rsp_err}, 6'b0);
        chk("reset alu", {alu_op, alu_a, alu_b, alu_imm, rsp_data}, {4'hF, 53'b0});
        reset = 1'b0;
        @(negedge clk);
        chk("ready after reset", req_ready, 1);

        for (int i = 0; i < 10; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].imm,
                    tbl[i].d, tbl[i].z, tbl[i].s, tbl[i].e, 0);

        run_txn("backpressure", 4'h0, 16'h1000, 16'h0234, 5'h00, 16'h1234, 1'b0, 1'b0, 1'b0, 5);

        // abort in WAIT: no response, outputs back to reset values, late ALU result ignored
        req_op = 4'h2; req_a = 16'hFFFF; req_b = 16'h1234; req_imm = 5'h04; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort in wait alu_op", alu_op, 4'hF);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort outputs", {req_ready, rsp_valid, busy, rsp_zero, rsp_sign, rsp_err}, 6'b0);
        chk("abort alu", {alu_op, alu_a, alu_b, alu_imm, rsp_data}, {4'hF, 53'b0});
        @(negedge clk);
        chk("abort ready", {req_ready, rsp_valid, busy}, 3'b100);
        repeat (3) @(negedge clk);
        chk("abort no rsp", rsp_valid, 0);
        run_txn("post abort or", 4'h3, 16'h00F0, 16'h000F, 5'h00, 16'h00FF, 1'b0, 1'b0, 1'b0, 0);

        run_txn("rand a0", 4'h8, 16'h0000, 16'h0003, 5'h00, mrng, mrng == 0, mrng[15], 1'b0, 0);
        mrng = step(mrng);

        for (int i = 0; i < 60; i++) begin
            op  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            a   = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            b   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            imm = 5'($urandom);
            legal = (op <= 4'h8) && !((op == 4'h5 || op == 4'h7) && b == 0);
            ed = !legal ? 16'h0 : (op == 4'h8) ? mrng : calc(op, a, b, imm);
            if (legal && op == 4'h8) mrng = step(mrng);
            run_txn($sformatf("rnd%0d", i), op, a, b, imm, ed, ed == 0, ed[15], !legal, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
